icache_assoc_refill: RTL and testbench



---
 rtl/icache_assoc_refill_if.sv | 44 ++++
 rtl/icache_assoc_refill.sv | 225 ++++++++++++++++++++++
 tb/tb_icache_assoc_refill.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_refill_if.sv
// Buses of the set-associative fetch cache: the pipeline request/response
// channel and the AXI read-address/read-data channels used for line refills.
interface icache_req_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic              resp_error;

  modport master (
    output req_valid, req_addr, req_size, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_error
  );
  modport slave (
    input  req_valid, req_addr, req_size, resp_ready,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

interface icache_axi_if #(parameter int ADDR_W = 64);
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [63:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
  );
  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast
  );
endinterface

// File: rtl/icache_assoc_refill.sv
// Read-only N-way set-associative cache with round-robin replacement, whole-line
// AXI INCR refills, error reporting, whole-cache flush and saturating hit/miss counters.
module icache_assoc_refill #(
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int ADDR_W     = 64
) (
  input  logic                clock,
  input  logic                reset,
  icache_req_if.slave         cpu,
  icache_axi_if.master        axi,
  input  logic                flush,
  output logic                flush_done,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BEATS  = LINE_BYTES / 8;
  localparam int WORD_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESPOND} state_t;

  state_t state;

  logic [63:0]      data_mem [SETS][WAYS][BEATS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAY_W-1:0] rr_ptr   [SETS];
  logic [63:0]      line_buf [BEATS];

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [WORD_W-1:0] beat_cnt;
  logic              err_q;
  logic [WAY_W-1:0]  victim;
  logic              victim_was_invalid;
  logic [63:0]       crit_word;
  logic              flush_pend;

  logic              resp_valid, resp_error, arvalid, rready;
  logic [63:0]       resp_data;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] word_idx;
  logic              flush_now;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  vic_way;
  logic              vic_invalid;
  logic              beat_err;
  logic              err_all;
  logic [63:0]       fill_word;

  assign idx       = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign word_idx  = (BEATS > 1) ? addr_q[3 +: WORD_W] : '0;
  assign flush_now = flush || flush_pend;

  // Flush is serviced combinationally in IDLE so the requester sees flush_done
  // in the same cycle the valid bits are cleared and can drop its level request.
  assign cpu.req_ready = (state == IDLE) && !flush_now;
  assign flush_done    = (state == IDLE) && flush_now;

  assign cpu.resp_valid    = resp_valid;
  assign cpu.resp_error    = resp_error;
  assign cpu.resp_data     = resp_data;
  assign axi.m_axi_arvalid = arvalid;
  assign axi.m_axi_araddr  = araddr;
  assign axi.m_axi_arlen   = arlen;
  assign axi.m_axi_arsize  = arsize;
  assign axi.m_axi_arburst = arburst;
  assign axi.m_axi_rready  = rready;

  function automatic logic [63:0] extract(input logic [63:0] word, input logic [2:0] off,
                                          input logic [1:0] size);
    logic [63:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    return {56'd0, sh[7:0]};
      2'd1:    return {48'd0, sh[15:0]};
      2'd2:    return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Victim preference: lowest-index invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    vic_way     = rr_ptr[idx];
    vic_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx][w] && (tag_mem[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[idx][w]) begin
        vic_way     = WAY_W'(w);
        vic_invalid = 1'b1;
      end
    end
  end

  assign beat_err  = (axi.m_axi_rresp != 2'b00)
                   || (axi.m_axi_rlast && (beat_cnt != LAST_BEAT))
                   || (!axi.m_axi_rlast && (beat_cnt == LAST_BEAT));
  assign err_all   = err_q || beat_err;
  assign fill_word = (beat_cnt == word_idx) ? axi.m_axi_rdata : crit_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
      hit_count          <= '0;
      miss_count         <= '0;
      resp_valid         <= 1'b0;
      resp_error         <= 1'b0;
      resp_data          <= '0;
      arvalid            <= 1'b0;
      rready             <= 1'b0;
      araddr             <= '0;
      arlen              <= '0;
      arsize             <= 3'd3;
      arburst            <= 2'd1;
      addr_q             <= '0;
      size_q             <= '0;
      beat_cnt           <= '0;
      err_q              <= 1'b0;
      victim             <= '0;
      victim_was_invalid <= 1'b0;
      crit_word          <= '0;
      flush_pend         <= 1'b0;
    end else begin
      if (flush && (state != IDLE)) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_now) begin
            for (int s = 0; s < SETS; s++) valid_mem[s] <= '0;
            flush_pend <= 1'b0;
          end else if (cpu.req_valid) begin
            addr_q <= cpu.req_addr;
            size_q <= cpu.req_size;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data  <= extract(data_mem[idx][hit_way][word_idx], addr_q[2:0], size_q);
            resp_valid <= 1'b1;
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            state      <= RESPOND;
          end else begin
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            victim             <= vic_way;
            victim_was_invalid <= vic_invalid;
            araddr             <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            arlen              <= 8'(BEATS - 1);
            arsize             <= 3'd3;
            arburst            <= 2'd1;
            arvalid            <= 1'b1;
            beat_cnt           <= '0;
            err_q              <= 1'b0;
            state              <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (axi.m_axi_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (axi.m_axi_rvalid) begin
            line_buf[beat_cnt] <= axi.m_axi_rdata;
            beat_cnt           <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            err_q              <= err_all;
            if (beat_cnt == word_idx) crit_word <= axi.m_axi_rdata;
            if (axi.m_axi_rlast) begin
              rready     <= 1'b0;
              resp_valid <= 1'b1;
              state      <= RESPOND;
              if (!err_all) begin
                for (int k = 0; k < BEATS; k++)
                  data_mem[idx][victim][k] <= (WORD_W'(k) == beat_cnt) ? axi.m_axi_rdata : line_buf[k];
                tag_mem[idx][victim]   <= tag;
                valid_mem[idx][victim] <= 1'b1;
                if (!victim_was_invalid)
                  rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;
                resp_data  <= extract(fill_word, addr_q[2:0], size_q);
                resp_error <= 1'b0;
              end else begin
                resp_data  <= '0;
                resp_error <= 1'b1;
              end
            end
          end
        end
        RESPOND: begin
          if (cpu.resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_assoc_refill.sv
// Directed bench for icache_assoc_refill: reset values, a table of hit/miss reads,
// then hand-written AXI error, backpressure, flush and reset-mid-refill sequences.
module tb_icache_assoc_refill;
  localparam int ADDR_W = 64;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] exp_data;
    bit          exp_miss;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [31:0] hit_count, miss_count;

  icache_req_if #(.ADDR_W(ADDR_W)) cpu_bus ();
  icache_axi_if #(.ADDR_W(ADDR_W)) axi_bus ();

  icache_assoc_refill #(.LINE_BYTES(64), .SETS(64), .WAYS(2), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .cpu(cpu_bus), .axi(axi_bus),
    .flush(flush), .flush_done(flush_done), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int ar_delay = 0;
  int err_beat = -1;
  int last_beat = 7;
  int ar_count = 0;
  int beat_total = 0;
  logic [63:0] cap_araddr;
  logic [7:0]  cap_arlen;
  logic [2:0]  cap_arsize;
  logic [1:0]  cap_arburst;

  function automatic logic [63:0] mem_word(input logic [63:0] line, input int k);
    if (line == 64'h1000) return 64'h1111_1111_1111_1111 * 64'(k);
    if (line == 64'h3040 && k == 0) return 64'h8877_6655_4433_2211;
    return {line[31:0], 32'(k)};
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] addr, input logic [1:0] size,
                                output logic [63:0] data, output logic err, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!cpu_bus.req_ready && n < 50) begin @(negedge clock); n++; end
    cpu_bus.req_valid = 1'b1;
    cpu_bus.req_addr  = addr;
    cpu_bus.req_size  = size;
    @(negedge clock);
    cpu_bus.req_valid = 1'b0;
    lat = 1;
    while (!cpu_bus.resp_valid && lat < 400) begin @(negedge clock); lat++; end
    check_output("resp_timeout", {63'd0, cpu_bus.resp_valid}, 64'd1);
    data = cpu_bus.resp_data;
    err  = cpu_bus.resp_error;
    cpu_bus.resp_ready = 1'b1;
    @(negedge clock);
    cpu_bus.resp_ready = 1'b0;
  endtask

  // AXI read slave: optional AR stall, INCR beats from mem_word, optional error
  // beat and early rlast; a synchronous reset abandons the burst.
  initial begin : axi_slave
    logic [63:0] line;
    int nb, b, waitc;
    bit took;
    axi_bus.m_axi_arready = 1'b0;
    axi_bus.m_axi_rvalid  = 1'b0;
    axi_bus.m_axi_rdata   = '0;
    axi_bus.m_axi_rresp   = 2'b00;
    axi_bus.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clock);
      if (axi_bus.m_axi_arvalid && !reset) begin
        waitc = 0;
        while (waitc < ar_delay && !reset) begin @(negedge clock); waitc++; end
        cap_araddr  = axi_bus.m_axi_araddr;
        cap_arlen   = axi_bus.m_axi_arlen;
        cap_arsize  = axi_bus.m_axi_arsize;
        cap_arburst = axi_bus.m_axi_arburst;
        axi_bus.m_axi_arready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_bus.m_axi_arready = 1'b0;
        if (!reset) begin
          ar_count++;
          line = cap_araddr;
          nb   = last_beat + 1;
          b    = 0;
          while (b < nb) begin
            axi_bus.m_axi_rvalid = 1'b1;
            axi_bus.m_axi_rdata  = mem_word(line, b);
            axi_bus.m_axi_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            axi_bus.m_axi_rlast  = (b == nb - 1);
            took = axi_bus.m_axi_rready;
            @(posedge clock);
            if (reset) break;
            @(negedge clock);
            if (took) begin b++; beat_total++; end
          end
          axi_bus.m_axi_rvalid = 1'b0;
          axi_bus.m_axi_rlast  = 1'b0;
          axi_bus.m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  initial begin : main
    vec_t vecs [12];
    logic [63:0] d;
    logic e;
    int lat, ar0, bt0, n;
    logic [63:0] addr0;

    vecs[0]  = '{64'h0008, 2'd3, 64'h0000_0000_0000_0001, 1'b1};
    vecs[1]  = '{64'h1010, 2'd3, 64'h2222_2222_2222_2222, 1'b1};
    vecs[2]  = '{64'h2018, 2'd3, 64'h0000_2000_0000_0003, 1'b1};
    vecs[3]  = '{64'h1038, 2'd3, 64'h7777_7777_7777_7777, 1'b0};
    vecs[4]  = '{64'h0000, 2'd3, 64'h0000_0000_0000_0000, 1'b1};
    vecs[5]  = '{64'h2004, 2'd2, 64'h0000_0000_0000_2000, 1'b0};
    vecs[6]  = '{64'h1020, 2'd1, 64'h0000_0000_0000_4444, 1'b1};
    vecs[7]  = '{64'h3043, 2'd0, 64'h0000_0000_0000_0044, 1'b1};
    vecs[8]  = '{64'h3046, 2'd1, 64'h0000_0000_0000_8877, 1'b0};
    vecs[9]  = '{64'h3044, 2'd2, 64'h0000_0000_8877_6655, 1'b0};
    vecs[10] = '{64'h3041, 2'd0, 64'h0000_0000_0000_0022, 1'b0};
    vecs[11] = '{64'h3048, 2'd3, 64'h0000_3040_0000_0001, 1'b0};

    cpu_bus.req_valid  = 1'b0;
    cpu_bus.req_addr   = '0;
    cpu_bus.req_size   = '0;
    cpu_bus.resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rst_req_ready",  {63'd0, cpu_bus.req_ready}, 64'd1);
    check_output("rst_resp_valid", {63'd0, cpu_bus.resp_valid}, 64'd0);
    check_output("rst_resp_error", {63'd0, cpu_bus.resp_error}, 64'd0);
    check_output("rst_resp_data",  cpu_bus.resp_data, 64'd0);
    check_output("rst_flush_done", {63'd0, flush_done}, 64'd0);
    check_output("rst_arvalid",    {63'd0, axi_bus.m_axi_arvalid}, 64'd0);
    check_output("rst_rready",     {63'd0, axi_bus.m_axi_rready}, 64'd0);
    check_output("rst_araddr",     axi_bus.m_axi_araddr, 64'd0);
    check_output("rst_arlen",      64'(axi_bus.m_axi_arlen), 64'd0);
    check_output("rst_arsize",     64'(axi_bus.m_axi_arsize), 64'd3);
    check_output("rst_arburst",    64'(axi_bus.m_axi_arburst), 64'd1);
    check_output("rst_hits",       64'(hit_count), 64'd0);
    check_output("rst_misses",     64'(miss_count), 64'd0);
    reset = 1'b0;

    ar0 = ar_count;
    apply_stimulus(64'h1008, 2'd3, d, e, lat);
    check_output("hp_miss_data", d, 64'h1111_1111_1111_1111);
    check_output("hp_miss_err", {63'd0, e}, 64'd0);
    check_output("hp_miss_ar", 64'(ar_count - ar0), 64'd1);
    check_output("hp_araddr", cap_araddr, 64'h1000);
    check_output("hp_arlen", 64'(cap_arlen), 64'd7);
    check_output("hp_arsize", 64'(cap_arsize), 64'd3);
    check_output("hp_arburst", 64'(cap_arburst), 64'd1);
    ar0 = ar_count;
    apply_stimulus(64'h100C, 2'd2, d, e, lat);
    check_output("hp_hit_data", d, 64'h1111_1111);
    check_output("hp_hit_lat", 64'(lat), 64'd2);
    check_output("hp_hit_ar", 64'(ar_count - ar0), 64'd0);
    check_output("hp_hits", 64'(hit_count), 64'd1);
    check_output("hp_misses", 64'(miss_count), 64'd1);

    @(negedge clock);
    flush = 1'b1;
    #1;
    check_output("idle_flush_done", {63'd0, flush_done}, 64'd1);
    check_output("idle_flush_rdy", {63'd0, cpu_bus.req_ready}, 64'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check_output("idle_flush_done_off", {63'd0, flush_done}, 64'd0);
    check_output("idle_flush_rdy_on", {63'd0, cpu_bus.req_ready}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      ar0 = ar_count;
      apply_stimulus(vecs[i].addr, vecs[i].size, d, e, lat);
      check_output($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check_output($sformatf("vec%0d_err", i), {63'd0, e}, 64'd0);
      check_output($sformatf("vec%0d_miss", i), 64'(ar_count - ar0), {63'd0, vecs[i].exp_miss});
      if (vecs[i].exp_miss)
        check_output($sformatf("vec%0d_araddr", i), cap_araddr, vecs[i].addr & ~64'h3F);
      else
        check_output($sformatf("vec%0d_lat", i), 64'(lat), 64'd2);
    end
    check_output("tbl_hits", 64'(hit_count), 64'd7);
    check_output("tbl_misses", 64'(miss_count), 64'd7);

    err_beat = 3;
    bt0 = beat_total;
    apply_stimulus(64'h5000, 2'd3, d, e, lat);
    check_output("rresp_err", {63'd0, e}, 64'd1);
    check_output("rresp_data", d, 64'd0);
    check_output("rresp_beats", 64'(beat_total - bt0), 64'd8);
    err_beat = -1;
    ar0 = ar_count;
    apply_stimulus(64'h5000, 2'd3, d, e, lat);
    check_output("rresp_retry_miss", 64'(ar_count - ar0), 64'd1);
    check_output("rresp_retry_data", d, 64'h0000_5000_0000_0000);
    check_output("rresp_retry_err", {63'd0, e}, 64'd0);

    last_beat = 5;
    bt0 = beat_total;
    apply_stimulus(64'h6008, 2'd3, d, e, lat);
    check_output("rlast_err", {63'd0, e}, 64'd1);
    check_output("rlast_data", d, 64'd0);
    check_output("rlast_beats", 64'(beat_total - bt0), 64'd6);
    last_beat = 7;
    ar0 = ar_count;
    apply_stimulus(64'h6008, 2'd3, d, e, lat);
    check_output("rlast_retry_miss", 64'(ar_count - ar0), 64'd1);
    check_output("rlast_retry_data", d, 64'h0000_6000_0000_0001);
    check_output("err_misses", 64'(miss_count), 64'd11);

    // AR stall of five cycles, then a response held for four cycles.
    ar_delay = 5;
    @(negedge clock);
    cpu_bus.req_valid = 1'b1;
    cpu_bus.req_addr  = 64'h7008;
    cpu_bus.req_size  = 2'd3;
    @(negedge clock);
    cpu_bus.req_valid = 1'b0;
    check_output("bp_arvalid_n1", {63'd0, axi_bus.m_axi_arvalid}, 64'd0);
    @(negedge clock);
    check_output("bp_arvalid_n2", {63'd0, axi_bus.m_axi_arvalid}, 64'd1);
    addr0 = axi_bus.m_axi_araddr;
    check_output("bp_araddr", addr0, 64'h7000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output($sformatf("bp_arvalid_hold%0d", i), {63'd0, axi_bus.m_axi_arvalid}, 64'd1);
      check_output($sformatf("bp_araddr_hold%0d", i), axi_bus.m_axi_araddr, 64'h7000);
    end
    ar_delay = 0;
    n = 0;
    while (!cpu_bus.resp_valid && n < 200) begin @(negedge clock); n++; end
    check_output("bp_resp_seen", {63'd0, cpu_bus.resp_valid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output($sformatf("bp_resp_valid%0d", i), {63'd0, cpu_bus.resp_valid}, 64'd1);
      check_output($sformatf("bp_resp_data%0d", i), cpu_bus.resp_data, 64'h0000_7000_0000_0001);
      check_output($sformatf("bp_req_ready%0d", i), {63'd0, cpu_bus.req_ready}, 64'd0);
    end
    cpu_bus.resp_ready = 1'b1;
    @(negedge clock);
    cpu_bus.resp_ready = 1'b0;
    check_output("bp_resp_cleared", {63'd0, cpu_bus.resp_valid}, 64'd0);
    check_output("bp_req_ready_back", {63'd0, cpu_bus.req_ready}, 64'd1);

    // Flush raised mid-refill waits for the first IDLE cycle.
    @(negedge clock);
    cpu_bus.req_valid = 1'b1;
    cpu_bus.req_addr  = 64'h8010;
    cpu_bus.req_size  = 2'd3;
    @(negedge clock);
    cpu_bus.req_valid = 1'b0;
    n = 0;
    while (!axi_bus.m_axi_rready && n < 100) begin @(negedge clock); n++; end
    check_output("fl_rready_seen", {63'd0, axi_bus.m_axi_rready}, 64'd1);
    flush = 1'b1;
    #1;
    check_output("fl_done_busy", {63'd0, flush_done}, 64'd0);
    n = 0;
    while (!cpu_bus.resp_valid && n < 100) begin @(negedge clock); n++; end
    check_output("fl_resp_data", cpu_bus.resp_data, 64'h0000_8000_0000_0002);
    check_output("fl_done_respond", {63'd0, flush_done}, 64'd0);
    cpu_bus.resp_ready = 1'b1;
    @(negedge clock);
    cpu_bus.resp_ready = 1'b0;
    check_output("fl_done_idle", {63'd0, flush_done}, 64'd1);
    check_output("fl_req_ready_idle", {63'd0, cpu_bus.req_ready}, 64'd0);
    flush = 1'b0;
    @(negedge clock);
    check_output("fl_done_off", {63'd0, flush_done}, 64'd0);
    ar0 = ar_count;
    apply_stimulus(64'h8010, 2'd3, d, e, lat);
    check_output("fl_reread_miss", 64'(ar_count - ar0), 64'd1);
    check_output("fl_reread_data", d, 64'h0000_8000_0000_0002);
    check_output("fl_misses", 64'(miss_count), 64'd14);

    // Reset in the middle of a burst.
    @(negedge clock);
    cpu_bus.req_valid = 1'b1;
    cpu_bus.req_addr  = 64'h9000;
    cpu_bus.req_size  = 2'd3;
    @(negedge clock);
    cpu_bus.req_valid = 1'b0;
    n = 0;
    while (!axi_bus.m_axi_rready && n < 100) begin @(negedge clock); n++; end
    check_output("rs_rready_seen", {63'd0, axi_bus.m_axi_rready}, 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("rs_req_ready", {63'd0, cpu_bus.req_ready}, 64'd1);
    check_output("rs_arvalid", {63'd0, axi_bus.m_axi_arvalid}, 64'd0);
    check_output("rs_rready", {63'd0, axi_bus.m_axi_rready}, 64'd0);
    check_output("rs_resp_valid", {63'd0, cpu_bus.resp_valid}, 64'd0);
    check_output("rs_hits", 64'(hit_count), 64'd0);
    check_output("rs_misses", 64'(miss_count), 64'd0);
    reset = 1'b0;
    ar0 = ar_count;
    apply_stimulus(64'h3048, 2'd3, d, e, lat);
    check_output("rs_reread_miss", 64'(ar_count - ar0), 64'd1);
    check_output("rs_reread_data", d, 64'h0000_3040_0000_0001);
    check_output("rs_post_misses", 64'(miss_count), 64'd1);
    check_output("rs_post_hits", 64'(hit_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
